// File: rtl/rlwe_dmem_dma_if.sv
// Data-memory request/response port between the RLWE DMA (master) and the TCM (slave).
// Encodings: cmd RD=0/WR=1; resp NOTRDY=0, RDY_OK=1, RDY_ER=2.
interface rlwe_dmem_dma_if #(
  parameter int AWIDTH = 32,
  parameter int VEC_W  = 128
);
  logic              req;
  logic              req_ack;
  logic              cmd;
  logic [1:0]        width;
  logic [AWIDTH-1:0] addr;
  logic [VEC_W-1:0]  wdata;
  logic [VEC_W-1:0]  rdata;
  logic [1:0]        resp;

  modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
  modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);
endinterface

// File: rtl/rlwe_dmem_dma.sv
// Burst initiator: turns one start command of N vector beats into N pipelined
// single-vector TCM requests, one outstanding at a time. Writes come from a
// valid/ready stream, reads drain through a small registered FIFO.
module rlwe_dmem_dma #(
  parameter int         LEN_W     = 8,
  parameter int         RD_DEPTH  = 2,
  parameter int         NUM_LANES = 4,
  parameter int         AWIDTH    = 32,
  parameter logic [1:0] VEC_WIDTH = 2'b11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        start_ready,
  input  logic                        start_wr,
  input  logic [AWIDTH-1:0]           start_addr,
  input  logic [LEN_W-1:0]            start_len,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [AWIDTH-1:0]           err_addr,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [NUM_LANES-1:0][31:0]  wr_data,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [NUM_LANES-1:0][31:0]  rd_data,
  rlwe_dmem_dma_if.master             dmem
);
  localparam logic       CMD_RD  = 1'b0;
  localparam logic [1:0] RESP_OK = 2'b01;
  localparam logic [1:0] RESP_ER = 2'b10;
  localparam int         PW      = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int         CW      = $clog2(RD_DEPTH + 1);
  localparam logic [AWIDTH-1:0] STRIDE = AWIDTH'(NUM_LANES * 4);

  typedef enum logic {IDLE, RUN} state_e;
  typedef logic [NUM_LANES-1:0][31:0] vec_t;

  state_e            state;
  logic              dir, outst, done_q, err_q;
  logic [AWIDTH-1:0] addr, beat_addr, err_addr_q;
  logic [LEN_W-1:0]  len, issued, acked;

  vec_t              fifo [RD_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  logic              rsp_ok, rsp_er, rsp_seen, slot_free, fifo_ok, issue, accept, push, pop;
  logic [CW:0]       occ;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(RD_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue decision: the next beat may go out in the same cycle the previous one completes OK.
  always_comb begin
    rsp_ok    = outst & (dmem.resp == RESP_OK);
    rsp_er    = outst & (dmem.resp == RESP_ER);
    rsp_seen  = rsp_ok | rsp_er;
    slot_free = ~outst | rsp_ok;
    pop       = rd_valid & rd_ready;
    occ       = {1'b0, count} + (CW+1)'(outst) - (CW+1)'(pop);
    fifo_ok   = occ < (CW+1)'(RD_DEPTH);
    issue     = (state == RUN) & (issued < len) & slot_free & (dir ? wr_valid : fifo_ok);
    accept    = issue & dmem.req_ack;
    push      = rsp_ok & (dir == CMD_RD);
  end

  assign dmem.req    = issue;
  assign dmem.cmd    = dir;
  assign dmem.width  = VEC_WIDTH;
  assign dmem.addr   = addr;
  // Gated so the bus shows zero data whenever no write request is being presented.
  assign dmem.wdata  = (issue & dir) ? wr_data : '0;
  assign wr_ready    = accept & dir;
  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign err_addr    = err_addr_q;
  assign rd_valid    = (count != '0);
  assign rd_data     = fifo[rptr];

  // Burst control: start latch, issue/ack bookkeeping, completion and abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= CMD_RD;
      outst      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr       <= '0;
      beat_addr  <= '0;
      err_addr_q <= '0;
      len        <= '0;
      issued     <= '0;
      acked      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        addr      <= addr + STRIDE;
        beat_addr <= addr;
        issued    <= issued + LEN_W'(1);
        outst     <= 1'b1;
      end else if (rsp_seen) begin
        outst <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          addr       <= start_addr;
          len        <= start_len;
          dir        <= start_wr;
          issued     <= '0;
          acked      <= '0;
          err_addr_q <= '0;
          if (start_len == '0) done_q <= 1'b1;
          else                 state  <= RUN;
        end
        RUN: begin
          if (rsp_ok) begin
            acked <= acked + LEN_W'(1);
            if (acked == len - LEN_W'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end else if (rsp_er) begin
            err_addr_q <= beat_addr;
            state      <= IDLE;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read FIFO: the issue rule reserves a slot per outstanding read, so push never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < RD_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= dmem.rdata;
        wptr       <= inc(wptr);
      end
      if (pop) rptr <= inc(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_rlwe_dmem_dma.sv
// Directed bench for rlwe_dmem_dma: a per-cycle vector table plus hand-written
// sequences for read back-pressure and a stalled request.
module tb_rlwe_dmem_dma;
  localparam int AW = 32;
  localparam int VW = 128;
  localparam logic [1:0] R_NO = 2'd0, R_OK = 2'd1, R_ER = 2'd2;

  logic clk = 1'b0;
  logic rst, start, start_ready, start_wr, busy, done, err, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] start_addr, err_addr;
  logic [7:0] start_len;
  logic [3:0][31:0] wr_data, rd_data;

  always #5 clk = ~clk;

  rlwe_dmem_dma_if #(.AWIDTH(AW), .VEC_W(VW)) dm();

  rlwe_dmem_dma #(.LEN_W(8), .RD_DEPTH(2), .NUM_LANES(4), .AWIDTH(AW), .VEC_WIDTH(2'b11)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready), .start_wr(start_wr),
    .start_addr(start_addr), .start_len(start_len), .busy(busy), .done(done), .err(err),
    .err_addr(err_addr), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .dmem(dm)
  );

  typedef struct {
    logic st, wr, wv, ack, rr, rt;
    logic [31:0] sa;
    logic [7:0] sl;
    logic [1:0] rs;
    logic q, wrr, d, e, b, rv;
    logic [31:0] qa, ea;
  } vec_t;

  int total = 0, passed = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t v(input int st, wr, sa, sl, wv, ack, rs, rr, rt,
                             input int q, qa, wrr, d, e, b, rv, ea);
    vec_t r;
    r.st = st[0]; r.wr = wr[0]; r.sa = sa; r.sl = sl[7:0]; r.wv = wv[0]; r.ack = ack[0];
    r.rs = rs[1:0]; r.rr = rr[0]; r.rt = rt[0];
    r.q = q[0]; r.qa = qa; r.wrr = wrr[0]; r.d = d[0]; r.e = e[0]; r.b = b[0]; r.rv = rv[0]; r.ea = ea;
    return r;
  endfunction

  task automatic apply(input vec_t r, input int i);
    @(negedge clk);
    rst = r.rt; start = r.st; start_wr = r.wr; start_addr = r.sa; start_len = r.sl;
    wr_valid = r.wv; dm.req_ack = r.ack; dm.resp = r.rs; rd_ready = r.rr;
    #1;
    chk($sformatf("row%0d req", i), dm.req, r.q);
    if (r.q) chk($sformatf("row%0d addr", i), dm.addr, r.qa);
    chk($sformatf("row%0d wr_ready", i), wr_ready, r.wrr);
    chk($sformatf("row%0d done", i), done, r.d);
    chk($sformatf("row%0d err", i), err, r.e);
    chk($sformatf("row%0d busy", i), busy, r.b);
    chk($sformatf("row%0d start_ready", i), start_ready, !r.b);
    chk($sformatf("row%0d rd_valid", i), rd_valid, r.rv);
    chk($sformatf("row%0d err_addr", i), err_addr, r.ea);
  endtask

  initial begin
    int req_cyc[$];
    logic [31:0] req_adr[$];
    logic [127:0] got[$];
    int done_cyc;
    logic pend, nxt;
    logic [127:0] pdata, ndata;
    logic [127:0] w0, w1;

    // cols: start wr addr len wv ack resp rr rst | req addr wr_ready done err busy rd_valid err_addr
    // Write len=4 @0x100, TCM-like responder: req cycles 1-4, done in cycle 6.
    tbl.push_back(v(1,1,'h100,4,1,1,R_NO,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_NO,0,0,     1,'h100,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_OK,0,0,     1,'h110,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_OK,0,0,     1,'h120,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_OK,0,0,     1,'h130,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_OK,0,0,     0,0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_NO,0,0,     0,0,0,1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_NO,0,0,     0,0,0,0,0,0,0,0));
    // Write len=4 @0x200, RDY_ER on beat 1: no third request, done+err, err_addr=0x210.
    tbl.push_back(v(1,1,'h200,4,1,1,R_NO,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_NO,0,0,     1,'h200,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_OK,0,0,     1,'h210,1,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_ER,0,0,     0,0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,1,1,R_NO,0,0,     0,0,0,1,1,0,0,'h210));
    tbl.push_back(v(0,0,0,0,1,1,R_NO,0,0,     0,0,0,0,0,0,0,'h210));
    // len=0: done next cycle, no request; start clears err_addr.
    tbl.push_back(v(1,0,'h0,0,0,1,R_NO,0,0,   0,0,0,0,0,0,0,'h210));
    tbl.push_back(v(0,0,0,0,0,1,R_NO,0,0,     0,0,0,1,0,0,0,0));
    // 8-beat read @0x400, reset in its cycle 3, late RDY_OK ignored, new start in cycle 5.
    tbl.push_back(v(1,0,'h400,8,0,1,R_NO,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,R_NO,0,0,     1,'h400,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,1,R_OK,0,0,     1,'h410,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,1,R_OK,0,1,     0,0,0,0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0,1,R_OK,0,0,     0,0,0,0,0,0,0,0));
    tbl.push_back(v(1,0,'h800,1,0,1,R_NO,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,1,R_NO,0,0,     1,'h800,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,1,R_OK,0,0,     0,0,0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,1,R_NO,0,0,     0,0,0,1,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,1,R_NO,1,0,     0,0,0,0,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,1,R_NO,0,0,     0,0,0,0,0,0,0,0));

    // Reset values, with nonzero stimulus on data inputs.
    rst = 1'b1; start = 1'b0; start_wr = 1'b1; start_addr = 32'h1234; start_len = 8'd5;
    wr_valid = 1'b1; wr_data = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555; rd_ready = 1'b0;
    dm.req_ack = 1'b1; dm.resp = R_OK; dm.rdata = 128'h77;
    repeat (2) @(negedge clk);
    rst = 1'b0; start_wr = 1'b0; wr_valid = 1'b0; dm.resp = R_NO;
    #1;
    chk("rst start_ready", start_ready, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst wr_ready", wr_ready, 1'b0);
    chk("rst rd_valid", rd_valid, 1'b0);
    chk("rst req", dm.req, 1'b0);
    chk("rst cmd", dm.cmd, 1'b0);
    chk("rst width", dm.width, 2'b11);
    chk("rst addr", dm.addr, 32'h0);
    chk("rst wdata", dm.wdata, 128'h0);
    chk("rst rd_data", rd_data, 128'h0);
    chk("rst err_addr", err_addr, 32'h0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Read len=3 @0x300 with rd_ready low in cycles 0-9; the slot freed by a pop
    // is usable in the pop cycle itself, so the third request goes out in cycle 10.
    pend = 1'b0; pdata = '0; done_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = (c == 0); start_wr = 1'b0; start_addr = 32'h300; start_len = 8'd3; wr_valid = 1'b0;
      dm.req_ack = 1'b1; dm.resp = pend ? R_OK : R_NO; dm.rdata = pdata; rd_ready = (c >= 10);
      #1;
      if (dm.req) begin
        req_cyc.push_back(c);
        req_adr.push_back(dm.addr);
        chk($sformatf("rd c%0d cmd", c), dm.cmd, 1'b0);
      end
      if (rd_valid && rd_ready) got.push_back(rd_data);
      if (done) done_cyc = c;
      nxt = dm.req;
      ndata = {4{32'hB000_0000 + ((dm.addr - 32'h300) >> 4)}};
      pend = nxt; pdata = ndata;
    end
    chk("rd nreq", req_cyc.size(), 3);
    chk("rd ngot", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd req%0d cyc", k), (k < req_cyc.size()) ? req_cyc[k] : -1, (k == 0) ? 1 : (k == 1) ? 2 : 10);
      chk($sformatf("rd req%0d addr", k), (k < req_adr.size()) ? req_adr[k] : 32'hFFFF_FFFF, 32'h300 + 32'(k * 16));
      chk($sformatf("rd data%0d", k), (k < got.size()) ? got[k] : 128'hX, {4{32'hB000_0000 + 32'(k)}});
    end
    chk("rd done cyc", done_cyc, 12);

    // Write len=2 @0x500 with req_ack low for three cycles: request held stable.
    w0 = 128'hA0A0_0001_A0A0_0002_A0A0_0003_A0A0_0004;
    w1 = 128'hB1B1_0001_B1B1_0002_B1B1_0003_B1B1_0004;
    @(negedge clk);
    start = 1'b1; start_wr = 1'b1; start_addr = 32'h500; start_len = 8'd2; wr_valid = 1'b1;
    wr_data = w0; dm.req_ack = 1'b0; dm.resp = R_NO; rd_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk($sformatf("stall c%0d req", c), dm.req, 1'b1);
      chk($sformatf("stall c%0d addr", c), dm.addr, 32'h500);
      chk($sformatf("stall c%0d wdata", c), dm.wdata, w0);
      chk($sformatf("stall c%0d wr_ready", c), wr_ready, 1'b0);
      chk($sformatf("stall c%0d cmd", c), dm.cmd, 1'b1);
    end
    @(negedge clk);
    dm.req_ack = 1'b1;
    #1;
    chk("stall c4 req", dm.req, 1'b1);
    chk("stall c4 addr", dm.addr, 32'h500);
    chk("stall c4 wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    wr_data = w1; dm.resp = R_OK;
    #1;
    chk("stall c5 req", dm.req, 1'b1);
    chk("stall c5 addr", dm.addr, 32'h510);
    chk("stall c5 wdata", dm.wdata, w1);
    chk("stall c5 wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    #1;
    chk("stall c6 req", dm.req, 1'b0);
    chk("stall c6 done", done, 1'b0);
    @(negedge clk);
    dm.resp = R_NO;
    #1;
    chk("stall c7 done", done, 1'b1);
    chk("stall c7 err", err, 1'b0);
    chk("stall c7 busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
